// File: rtl/mem_msg_pkg.sv
// Shared message codes and arbiter state encoding for the main-memory channel.
package mem_msg_pkg;

    localparam logic [3:0] NO_REQ    = 4'd0;
    localparam logic [3:0] R_REQ     = 4'd1;
    localparam logic [3:0] WB_REQ    = 4'd2;
    localparam logic [3:0] MEM_RESP  = 4'd3;
    localparam logic [3:0] MEM_READY = 4'd4;
    localparam logic [3:0] ARB_ERR   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/main_memory_arbiter_if.sv
// Bundle of requester-side and memory-side channels of the main-memory arbiter.
// master: requesters plus memory (drive requests and memory responses).
// slave : the arbiter itself.
interface main_memory_arbiter_if #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4
);
    logic [NUM_PORTS*MSG_BITS-1:0]      req_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    req_data;
    logic [NUM_PORTS*MSG_BITS-1:0]      resp_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] resp_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    resp_data;
    logic [MSG_BITS-1:0]                arb2mem_msg;
    logic [ADDRESS_WIDTH-1:0]           arb2mem_address;
    logic [DATA_WIDTH-1:0]              arb2mem_data;
    logic [MSG_BITS-1:0]                mem2arb_msg;
    logic [ADDRESS_WIDTH-1:0]           mem2arb_address;
    logic [DATA_WIDTH-1:0]              mem2arb_data;
    logic [NUM_PORTS-1:0]               grant;
    logic                               busy;
    logic                               timeout_error;

    modport master (
        output req_msg, req_address, req_data,
        output mem2arb_msg, mem2arb_address, mem2arb_data,
        input  resp_msg, resp_address, resp_data,
        input  arb2mem_msg, arb2mem_address, arb2mem_data,
        input  grant, busy, timeout_error
    );

    modport slave (
        input  req_msg, req_address, req_data,
        input  mem2arb_msg, mem2arb_address, mem2arb_data,
        output resp_msg, resp_address, resp_data,
        output arb2mem_msg, arb2mem_address, arb2mem_data,
        output grant, busy, timeout_error
    );
endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first requester scanning upward from
// last_grant+1 (wrapping), returned as one-hot grant plus index.
module rr_priority_select #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);
    int   cand_s;
    logic found_s;
    logic hit_s;

    // Walk the ports in rotated order and latch the first hit only
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        cand_s    = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand_s         = (int'(last_grant) + k) % NUM_PORTS;
            hit_s          = request[cand_s] && !found_s;
            grant[cand_s]  = grant[cand_s] | hit_s;
            grant_idx      = hit_s ? IDX_W'(cand_s) : grant_idx;
            found_s        = found_s | hit_s;
        end
    end
endmodule

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing the single-ported main_memory channel among
// NUM_PORTS requesters, one transaction in flight at a time.
// Optional watchdog on the WAIT state: define MEM_ARB_TIMEOUT_EN.
module main_memory_arbiter
    import mem_msg_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MSG_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clock,
    input logic reset,
    main_memory_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam logic [MSG_BITS-1:0] M_NO_REQ    = MSG_BITS'(NO_REQ);
    localparam logic [MSG_BITS-1:0] M_MEM_RESP  = MSG_BITS'(MEM_RESP);
    localparam logic [MSG_BITS-1:0] M_MEM_READY = MSG_BITS'(MEM_READY);

    arb_state_t                         state_q, state_d;
    logic [IDX_W-1:0]                   last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0]               grant_q, grant_d;
    logic [MSG_BITS-1:0]                arb_msg_q, arb_msg_d;
    logic [ADDRESS_WIDTH-1:0]           arb_addr_q, arb_addr_d;
    logic [DATA_WIDTH-1:0]              arb_data_q, arb_data_d;
    logic [NUM_PORTS*MSG_BITS-1:0]      resp_msg_q, resp_msg_d;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] resp_addr_q, resp_addr_d;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
    logic [NUM_PORTS-1:0]               request_s;
    logic [NUM_PORTS-1:0]               sel_grant_s;
    logic [IDX_W-1:0]                   sel_idx_s;
    logic                               mem_ack_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [MSG_BITS-1:0] M_ARB_ERR = MSG_BITS'(ARB_ERR);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_error_q, timeout_error_d;
`endif

    // Flag every port whose request code is not NO_REQ
    always_comb begin
        request_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            request_s[p] = (bus.req_msg[p*MSG_BITS +: MSG_BITS] != M_NO_REQ);
        end
    end

    assign mem_ack_s = (bus.mem2arb_msg == M_MEM_RESP) || (bus.mem2arb_msg == M_MEM_READY);

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .request    (request_s),
        .last_grant (last_grant_q),
        .grant      (sel_grant_s),
        .grant_idx  (sel_idx_s)
    );

    // Next-state and capture logic of the IDLE/WAIT/DONE transaction FSM
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        arb_msg_d    = arb_msg_q;
        arb_addr_d   = arb_addr_q;
        arb_data_d   = arb_data_q;
        resp_msg_d   = resp_msg_q;
        resp_addr_d  = resp_addr_q;
        resp_data_d  = resp_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wd_cnt_d        = wd_cnt_q;
        timeout_error_d = timeout_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (|request_s) begin
                    arb_msg_d    = bus.req_msg[int'(sel_idx_s)*MSG_BITS +: MSG_BITS];
                    arb_addr_d   = bus.req_address[int'(sel_idx_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    arb_data_d   = bus.req_data[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                    grant_d      = sel_grant_s;
                    last_grant_d = sel_idx_s;
                    state_d      = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_cnt_d     = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
`ifdef MEM_ARB_TIMEOUT_EN
                wd_cnt_d = (wd_cnt_q == WD_LIMIT) ? wd_cnt_q : wd_cnt_q + 1'b1;
`endif
                if (mem_ack_s) begin
                    resp_msg_d[int'(last_grant_q)*MSG_BITS +: MSG_BITS]              = bus.mem2arb_msg;
                    resp_addr_d[int'(last_grant_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH]   = bus.mem2arb_address;
                    resp_data_d[int'(last_grant_q)*DATA_WIDTH +: DATA_WIDTH]         = bus.mem2arb_data;
                    arb_msg_d = M_NO_REQ;
                    state_d   = DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // A response on the limit cycle takes the branch above instead
                else if (wd_cnt_d == WD_LIMIT) begin
                    resp_msg_d[int'(last_grant_q)*MSG_BITS +: MSG_BITS]              = M_ARB_ERR;
                    resp_addr_d[int'(last_grant_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH]   = '0;
                    resp_data_d[int'(last_grant_q)*DATA_WIDTH +: DATA_WIDTH]         = '0;
                    arb_msg_d       = M_NO_REQ;
                    timeout_error_d = 1'b1;
                    state_d         = DONE;
                end
`endif
                else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                // No arbitration here: the served port's stale request is still visible
                resp_msg_d  = '0;
                resp_addr_d = '0;
                resp_data_d = '0;
                grant_d     = '0;
                state_d     = IDLE;
            end
            default: begin
                resp_msg_d  = '0;
                resp_addr_d = '0;
                resp_data_d = '0;
                grant_d     = '0;
                arb_msg_d   = M_NO_REQ;
                state_d     = IDLE;
            end
        endcase
    end

    // FSM, grant and capture registers; reset drops any in-flight transaction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            grant_q      <= '0;
            arb_msg_q    <= M_NO_REQ;
            arb_addr_q   <= '0;
            arb_data_q   <= '0;
            resp_msg_q   <= '0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            arb_msg_q    <= arb_msg_d;
            arb_addr_q   <= arb_addr_d;
            arb_data_q   <= arb_data_d;
            resp_msg_q   <= resp_msg_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt_q        <= '0;
            timeout_error_q <= 1'b0;
        end else begin
            wd_cnt_q        <= wd_cnt_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    assign bus.timeout_error = timeout_error_q;
`else
    assign bus.timeout_error = 1'b0;
`endif

    assign bus.grant           = grant_q;
    assign bus.busy            = (state_q == WAIT) || (state_q == DONE);
    assign bus.arb2mem_msg     = arb_msg_q;
    assign bus.arb2mem_address = arb_addr_q;
    assign bus.arb2mem_data    = arb_data_q;
    assign bus.resp_msg        = resp_msg_q;
    assign bus.resp_address    = resp_addr_q;
    assign bus.resp_data       = resp_data_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed self-checking bench for main_memory_arbiter (4 ports, 16-cycle watchdog).
module tb_main_memory_arbiter;
    import mem_msg_pkg::*;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 4;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [3:0]   exp_g;
    logic [15:0]  exp_msg;
    logic [127:0] exp_data;
    int           p;

    main_memory_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB)) bus ();

    main_memory_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int port, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        bus.req_msg[port*MB +: MB]     = m;
        bus.req_address[port*AW +: AW] = a;
        bus.req_data[port*DW +: DW]    = d;
    endtask

    task automatic mem(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        bus.mem2arb_msg     = m;
        bus.mem2arb_address = a;
        bus.mem2arb_data    = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset = 1'b1;
        bus.req_msg = '0; bus.req_address = '0; bus.req_data = '0;
        mem(NO_REQ, 32'h0, 32'h0);
        step(); step();
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_arb_msg", bus.arb2mem_msg, NO_REQ);
        chk("rst_arb_addr", bus.arb2mem_address, 32'h0);
        chk("rst_resp_msg", bus.resp_msg, 16'h0);
        chk("rst_resp_data", bus.resp_data, 128'h0);
        chk("rst_timeout", bus.timeout_error, 1'b0);
        reset = 1'b0;
        step();

        // Single read from port 0, memory answers 5 cycles after the request
        set_req(0, R_REQ, 32'h40, 32'h0);
        step();
        chk("rd_arb_msg", bus.arb2mem_msg, R_REQ);
        chk("rd_arb_addr", bus.arb2mem_address, 32'h40);
        chk("rd_grant", bus.grant, 4'b0001);
        chk("rd_busy", bus.busy, 1'b1);
        step(); step(); step(); step();
        chk("rd_wait_resp", bus.resp_msg, 16'h0);
        chk("rd_wait_arb", bus.arb2mem_msg, R_REQ);
        mem(MEM_RESP, 32'h40, 32'hDEADBEEF);
        step();
        chk("rd_resp_msg", bus.resp_msg, 16'h0003);
        chk("rd_resp_data", bus.resp_data, {96'h0, 32'hDEADBEEF});
        chk("rd_resp_addr", bus.resp_address, {96'h0, 32'h40});
        chk("rd_done_arb", bus.arb2mem_msg, NO_REQ);
        chk("rd_done_busy", bus.busy, 1'b1);
        set_req(0, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        chk("rd_clear_msg", bus.resp_msg, 16'h0);
        chk("rd_clear_data", bus.resp_data, 128'h0);
        chk("rd_clear_grant", bus.grant, 4'b0000);
        chk("rd_idle_busy", bus.busy, 1'b0);

        // Write from port 1
        set_req(1, WB_REQ, 32'h80, 32'h12345678);
        step();
        chk("wr_arb_msg", bus.arb2mem_msg, WB_REQ);
        chk("wr_arb_addr", bus.arb2mem_address, 32'h80);
        chk("wr_arb_data", bus.arb2mem_data, 32'h12345678);
        chk("wr_grant", bus.grant, 4'b0010);
        mem(MEM_READY, 32'h80, 32'h0);
        step();
        chk("wr_resp_msg", bus.resp_msg, 16'h0040);
        chk("wr_resp_addr", bus.resp_address, {64'h0, 32'h80, 32'h0});
        set_req(1, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        chk("wr_clear_msg", bus.resp_msg, 16'h0);

        // Contention between ports 0 and 1, each re-requesting after service
        set_req(0, R_REQ, 32'h10, 32'h0);
        set_req(1, R_REQ, 32'h14, 32'h0);
        for (int t = 0; t < 4; t++) begin
            p        = t % 2;
            exp_g    = (p == 0) ? 4'b0001 : 4'b0010;
            exp_msg  = (p == 0) ? 16'h0003 : 16'h0030;
            exp_data = 128'(32'hA000_0000 + 32'(t)) << (p * 32);
            step();
            chk("cont_grant", bus.grant, exp_g);
            mem(MEM_RESP, 32'h10, 32'hA000_0000 + 32'(t));
            step();
            chk("cont_resp_msg", bus.resp_msg, exp_msg);
            chk("cont_resp_data", bus.resp_data, exp_data);
            set_req(p, NO_REQ, 32'h0, 32'h0);
            mem(NO_REQ, 32'h0, 32'h0);
            step();
            chk("cont_idle_grant", bus.grant, 4'b0000);
            if (t < 3) begin
                set_req(p, R_REQ, (p == 0) ? 32'h10 : 32'h14, 32'h0);
            end else begin
                set_req(0, NO_REQ, 32'h0, 32'h0);
            end
        end
        step();
        chk("cont_end_grant", bus.grant, 4'b0000);

        // Priority after reset: ports 2 and 3, then port 0 joins
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(2, R_REQ, 32'h200, 32'h0);
        set_req(3, R_REQ, 32'h300, 32'h0);
        step();
        chk("prio_grant2", bus.grant, 4'b0100);
        chk("prio_addr2", bus.arb2mem_address, 32'h200);
        set_req(0, R_REQ, 32'h20, 32'h0);
        mem(MEM_RESP, 32'h200, 32'h2222);
        step();
        chk("prio_resp2", bus.resp_msg, 16'h0300);
        set_req(2, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        step();
        chk("prio_grant3", bus.grant, 4'b1000);
        mem(MEM_RESP, 32'h300, 32'h3333);
        step();
        chk("prio_resp3", bus.resp_msg, 16'h3000);
        chk("prio_data3", bus.resp_data, {32'h3333, 96'h0});
        set_req(3, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        step();
        chk("prio_grant0", bus.grant, 4'b0001);
        chk("prio_addr0", bus.arb2mem_address, 32'h20);
        mem(MEM_RESP, 32'h20, 32'h0);
        step();
        chk("prio_resp0", bus.resp_msg, 16'h0003);
        set_req(0, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        chk("prio_idle_busy", bus.busy, 1'b0);

        // Reset in the middle of WAIT; port 0 must win again afterwards
        set_req(0, R_REQ, 32'h44, 32'h0);
        step();
        chk("rw_grant", bus.grant, 4'b0001);
        step(); step();
        #2;
        reset = 1'b1;
        #1;
        chk("rw_async_grant", bus.grant, 4'b0000);
        chk("rw_async_busy", bus.busy, 1'b0);
        chk("rw_async_arb_msg", bus.arb2mem_msg, NO_REQ);
        chk("rw_async_arb_addr", bus.arb2mem_address, 32'h0);
        chk("rw_async_resp", bus.resp_msg, 16'h0);
        set_req(1, R_REQ, 32'h55, 32'h0);
        step();
        chk("rw_held_grant", bus.grant, 4'b0000);
        reset = 1'b0;
        step();
        chk("rw_after_grant", bus.grant, 4'b0001);
        chk("rw_after_addr", bus.arb2mem_address, 32'h44);
        mem(MEM_RESP, 32'h44, 32'h4444);
        step();
        chk("rw_resp0", bus.resp_msg, 16'h0003);
        set_req(0, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        step();
        chk("rw_grant1", bus.grant, 4'b0010);
        mem(MEM_RESP, 32'h55, 32'h5555);
        step();
        chk("rw_resp1", bus.resp_msg, 16'h0030);
        set_req(1, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        chk("pre_to_flag", bus.timeout_error, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Silent memory: ARB_ERR arrives in the 17th cycle counting the grant cycle
        set_req(0, R_REQ, 32'h60, 32'h0);
        step();
        chk("to_grant", bus.grant, 4'b0001);
        repeat (15) step();
        chk("to_before_resp", bus.resp_msg, 16'h0);
        chk("to_before_flag", bus.timeout_error, 1'b0);
        chk("to_before_busy", bus.busy, 1'b1);
        step();
        chk("to_err_msg", bus.resp_msg, 16'h000F);
        chk("to_err_data", bus.resp_data, 128'h0);
        chk("to_flag", bus.timeout_error, 1'b1);
        chk("to_arb_msg", bus.arb2mem_msg, NO_REQ);
        set_req(0, NO_REQ, 32'h0, 32'h0);
        step();
        chk("to_clear_resp", bus.resp_msg, 16'h0);
        chk("to_clear_grant", bus.grant, 4'b0000);
        chk("to_sticky", bus.timeout_error, 1'b1);
        set_req(1, WB_REQ, 32'h84, 32'hCAFE0001);
        step();
        chk("to_next_grant", bus.grant, 4'b0010);
        chk("to_next_data", bus.arb2mem_data, 32'hCAFE0001);
        mem(MEM_READY, 32'h84, 32'h0);
        step();
        chk("to_next_resp", bus.resp_msg, 16'h0040);
        chk("to_next_sticky", bus.timeout_error, 1'b1);
        set_req(1, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        chk("to_end_busy", bus.busy, 1'b0);
`else
        // No watchdog: a silent memory leaves the transaction pending
        set_req(0, R_REQ, 32'h60, 32'h0);
        step();
        chk("nto_grant", bus.grant, 4'b0001);
        repeat (20) step();
        chk("nto_hold_grant", bus.grant, 4'b0001);
        chk("nto_hold_busy", bus.busy, 1'b1);
        chk("nto_hold_resp", bus.resp_msg, 16'h0);
        chk("nto_flag", bus.timeout_error, 1'b0);
        mem(MEM_RESP, 32'h60, 32'h6666);
        step();
        chk("nto_resp", bus.resp_msg, 16'h0003);
        set_req(0, NO_REQ, 32'h0, 32'h0);
        mem(NO_REQ, 32'h0, 32'h0);
        step();
        chk("nto_end_busy", bus.busy, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Round-robin arbiter that shares the single-ported `main_memory` message channel among `NUM_PORTS` requesters, for example per-cluster `main_memory_interface` instances or a future DMA/debug port. It holds one transaction in flight at a time, returns the memory's response only to the granted requester, then rotates priority. It sits between the requesters' `interface2mem_*`/`mem2interface_*` channels and `main_memory`'s `msg_in`/`msg_out` ports.

## Interface
- `NUM_PORTS`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 32: data word width.
- `ADDRESS_WIDTH`, 32: address width.
- `MSG_BITS`, 4: message code width.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in WAIT. Used only with `MEM_ARB_TIMEOUT_EN`.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_msg`  in  NUM_PORTS*MSG_BITS  per-port request code; NO_REQ means idle.
- `req_address`  in  NUM_PORTS*ADDRESS_WIDTH  per-port request address.
- `req_data`  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- `resp_msg`  out  NUM_PORTS*MSG_BITS  per-port response code; reset NO_REQ.
- `resp_address`  out  NUM_PORTS*ADDRESS_WIDTH  per-port response address; reset 0.
- `resp_data`  out  NUM_PORTS*DATA_WIDTH  per-port response data; reset 0.
- `arb2mem_msg`  out  MSG_BITS  message to memory; reset NO_REQ.
- `arb2mem_address`  out  ADDRESS_WIDTH  address to memory; reset 0.
- `arb2mem_data`  out  DATA_WIDTH  data to memory; reset 0.
- `mem2arb_msg`  in  MSG_BITS  message from memory.
- `mem2arb_address`  in  ADDRESS_WIDTH  address from memory.
- `mem2arb_data`  in  DATA_WIDTH  data from memory.
- `grant`  out  NUM_PORTS  one-hot owner of the in-flight transaction; reset 0.
- `busy`  out  1  high in WAIT or DONE; reset 0.
- `timeout_error`  out  1  sticky watchdog flag; reset 0, tied 0 without the macro.

## Operation
- Message codes: NO_REQ=0, R_REQ=1, WB_REQ=2, MEM_RESP=3 (read data), MEM_READY=4 (write ack), ARB_ERR=15.
- A requester holds `req_*` stable from assertion until it sees a non-NO_REQ `resp_msg`. It must drop to NO_REQ on the cycle after that.
- State machine:
  - IDLE: if any `req_msg` is not NO_REQ, pick the first requesting port scanning upward from `last_grant+1` (mod NUM_PORTS). Capture that port's request into the `arb2mem_*` registers, set `grant` and `last_grant`, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: `arb2mem_*` hold the captured request. When `mem2arb_msg` is MEM_RESP or MEM_READY, register it together with `mem2arb_address` and `mem2arb_data` into the granted port's `resp_*`, drive `arb2mem_msg` to NO_REQ, and go to DONE. Any other `mem2arb_msg` is ignored.
  - DONE: lasts one cycle. `resp_*` of the granted port clear to NO_REQ/0, `grant` clears to 0, next state is IDLE. No arbitration happens in DONE, so a requester's stale request cannot be re-granted.
- Response and address fields of non-granted ports are always NO_REQ/0.
- `last_grant` resets to NUM_PORTS-1, so port 0 has first priority after reset.
- Reset at any point, including mid-WAIT, returns to IDLE with every output at its reset value. The in-flight transaction is dropped.

## Timing
- Request visible in cycle N while in IDLE → `arb2mem_msg` and `grant` valid from N+1.
- `mem2arb_msg` response in cycle M → `resp_msg` of the granted port valid for exactly cycle M+1 → state IDLE at M+2.
- Fastest turnaround is 3 cycles per transaction, plus the memory's latency.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order. Every continuously requesting port is served within NUM_PORTS transactions.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A saturating counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no response, the arbiter sets `timeout_error` (sticky until reset) and drives the granted port's `resp_msg` to ARB_ERR with `resp_data` 0. `arb2mem_msg` goes to NO_REQ and the state moves to DONE.
  - A response arriving on the same cycle the counter reaches the limit wins, and no error is raised.
- Macro undefined: there is no counter, WAIT waits indefinitely, and `timeout_error` is constant 0.

## Structure
- Shared package `mem_msg_pkg` holds the message code constants (NO_REQ, R_REQ, WB_REQ, MEM_RESP, MEM_READY, ARB_ERR) and the arbiter state enumeration (IDLE, WAIT, DONE).
- One sub-module, `rr_priority_select`: a combinational round-robin picker with inputs `request[NUM_PORTS]` and `last_grant`, and outputs a one-hot grant and its index.
- The FSM, capture registers and watchdog live in the top module.

## Test plan
- Single read: port 0 R_REQ at address 0x40; memory returns MEM_RESP with data 0xDEADBEEF 5 cycles later → `arb2mem_msg`=1 from N+1, `grant`=01, port 0 `resp_msg`=3 and `resp_data`=0xDEADBEEF for exactly one cycle, port 1 `resp_msg`=0.
- Write: port 1 WB_REQ at address 0x80 with data 0x12345678 → memory sees msg 2, address 0x80, data 0x12345678; MEM_READY reaches port 1 only.
- Contention: ports 0 and 1 request together and re-request after each response → grants alternate 01, 10, 01, 10; neither port is granted twice in a row.
- Priority after reset: with NUM_PORTS=4, ports 2 and 3 request first → port 2 wins. Port 0 joins while port 2 is in flight → order is 3 then 0.
- Reset mid-WAIT: assert `reset` 2 cycles after the grant → all outputs 0/NO_REQ immediately; after release, port 0 is served first.
- Timeout (macro defined, TIMEOUT_CYCLES=16, memory silent): port 0 receives ARB_ERR in the 17th cycle after the grant and `timeout_error`=1 stays set. A following port 1 request still completes normally.
